magnitude_peak_detector: RTL and testbench
==========================================

# magnitude_peak_detector

Frame-based peak and energy detector that sits directly downstream of the CORDIC magnitude stage. It consumes one 13-bit magnitude per valid cycle. Over a frame of `FRAME_LEN` samples it finds the largest magnitude, the index of that sample, and the sum of all magnitudes. It presents the result through a valid/ready output register that holds until the consumer accepts it.

## Interface
Parameters:
- `FRAME_LEN`, default 64: samples per frame; must be a power of two, ≥ 2.
- `MAG_W`, default 13: magnitude width; input treated as unsigned.
- `IDX_W`, derived as $clog2(`FRAME_LEN`): index and counter width. Localparam, not overridable.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1  system clock, rising edge.
- `Reset_n`  in  1  asynchronous active-low reset.
- `Start`  in  1  single-cycle pulse that arms a new frame.
- `Mag_Valid`  in  1  `Magnitude` is valid this cycle.
- `Magnitude`  in  `MAG_W`  magnitude from the upstream stage.
- `Peak_Valid`  out  1  result registers hold a completed frame.
- `Peak_Ready`  in  1  consumer accepts the result.
- `Peak_Mag`  out  `MAG_W`  largest magnitude in the frame.
- `Peak_Idx`  out  `IDX_W`  sample index of the first occurrence of `Peak_Mag`.
- `Mag_Sum`  out  `MAG_W+IDX_W`  sum of all magnitudes in the frame.
- `Busy`  out  1  state is not IDLE.
- `Overrun`  out  1  sticky flag: a valid sample was dropped.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - `Start` clears the counter, running peak, peak index, running sum and `Overrun`, then goes to ACCUM.
- ACCUM, on each `Mag_Valid`:
  - sum += `Magnitude`; counter++.
  - When the counter is 0, the running peak is loaded unconditionally with the sample and the index becomes 0.
  - Otherwise the peak and index update only if `Magnitude` > running peak. The comparison is strict, so on a tie the earliest index wins.
  - Cycles with `Mag_Valid`=0 are gaps and leave all state unchanged.
- Frame end: on a valid sample when counter == `FRAME_LEN-1`:
  - the final peak, index and sum, including this sample, are latched into `Peak_Mag`, `Peak_Idx` and `Mag_Sum`;
  - `Peak_Valid` goes to 1 and the state goes to HOLD.
- HOLD:
  - Outputs stay stable while `Peak_Ready`=0.
  - On `Peak_Valid`&&`Peak_Ready` the state goes to IDLE and `Peak_Valid` clears at the next edge.
  - If `Start` arrives in the handshake cycle, the state goes directly to ACCUM with cleared internal state. The output registers keep their last values.
- Dropped samples: `Mag_Valid` in IDLE or HOLD is discarded and sets `Overrun`.
- `Start` is ignored in ACCUM, and in HOLD unless the handshake completes in the same cycle.
- Width: `Mag_Sum` is sized for `FRAME_LEN`·(2^`MAG_W`−1), so it never overflows.

## Timing
- Reset (`Reset_n`=0, asynchronous):
  - state becomes IDLE;
  - `Peak_Valid`, `Peak_Mag`, `Peak_Idx`, `Mag_Sum`, `Busy` and `Overrun` become 0;
  - the counter and accumulators are cleared.
- Reset during ACCUM or HOLD abandons the frame; no partial result is presented.
- Latency: `Peak_Valid` rises at the clock edge that samples the last valid input, so it is visible in the following cycle.
- `Busy` rises at the edge that samples `Start`. It falls at the handshake edge unless `Start` arrives in the same cycle.
- Throughput: one sample per cycle. Back-to-back frames lose no samples only if the next frame's `Start` coincides with the handshake.
- `Overrun` is set at the edge that sees the dropped sample and is cleared only by an accepted `Start` or by reset.

## Structure
- Shared package holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - `MAG_W` default 13, matching the magnitude stage output.
- One sub-module, `mag_frame_counter`:
  - `IDX_W`-bit counter with a clear input and an increment-enable input;
  - asserts `last` when count == `FRAME_LEN-1`.
- The compare, accumulate, output registers and FSM stay in the top module.

## Test plan
- Reset check: hold `Reset_n`=0 mid-run → every output is 0 and `Busy`=0; after release, `Mag_Valid` without `Start` → `Overrun`=1 and `Peak_Valid` stays 0.
- Ramp, `FRAME_LEN`=8: `Start`, then 1..8 on consecutive valid cycles, `Peak_Ready`=1 → one cycle after the 8th sample `Peak_Valid`=1, `Peak_Mag`=8, `Peak_Idx`=7, `Mag_Sum`=36; `Peak_Valid`=0 on the next cycle.
- Tie and gaps: samples 5,9,2,9,0,0,0,1 with random idle gaps → `Peak_Mag`=9, `Peak_Idx`=1, `Mag_Sum`=26.
- Backpressure and overrun: frame completes with `Peak_Ready`=0 for 5 cycles while `Mag_Valid`=1 with value 4095 → outputs unchanged, `Overrun`=1; `Peak_Ready`=1 → state goes to IDLE.
- Full scale, `FRAME_LEN`=64: all samples 4095 → `Peak_Mag`=4095, `Peak_Idx`=0, `Mag_Sum`=262080.
- Reset mid-frame and Start-on-handshake: assert reset after 4 samples, then run a clean frame → result independent of the aborted data; `Start` in the handshake cycle → `Busy` stays 1 and the next frame accumulates from zero.

Source files
------------

// File: rtl/magnitude_peak_detector_pkg.sv
// Shared types and defaults for the magnitude peak/energy detector.
package magnitude_peak_detector_pkg;

  localparam int MAG_W_DEFAULT = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mag_frame_counter.sv
// Sample counter for one frame; Last flags the final sample position.
module mag_frame_counter #(
  parameter int  FRAME_LEN = 64,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Inc,
  output logic [IDX_W-1:0] Count,
  output logic             Last
);

  // FRAME_LEN is a power of two, so the counter wraps to zero after the last sample.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (Inc) begin
      Count <= Count + IDX_W'(1);
    end
  end

  assign Last = (Count == IDX_W'(FRAME_LEN - 1));

endmodule

// File: rtl/magnitude_peak_detector.sv
// Per-frame peak, peak index and magnitude sum, presented through a valid/ready result register.
module magnitude_peak_detector
  import magnitude_peak_detector_pkg::*;
#(
  parameter int  FRAME_LEN = 64,
  parameter int  MAG_W     = MAG_W_DEFAULT,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   Mag_Valid,
  input  logic [MAG_W-1:0]       Magnitude,
  output logic                   Peak_Valid,
  input  logic                   Peak_Ready,
  output logic [MAG_W-1:0]       Peak_Mag,
  output logic [IDX_W-1:0]       Peak_Idx,
  output logic [MAG_W+IDX_W-1:0] Mag_Sum,
  output logic                   Busy,
  output logic                   Overrun
);

  localparam int SUM_W = MAG_W + IDX_W;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   count;
  logic               frame_last;
  logic [MAG_W-1:0]   run_peak;
  logic [IDX_W-1:0]   run_idx;
  logic [SUM_W-1:0]   run_sum;
  logic [MAG_W-1:0]   next_peak;
  logic [IDX_W-1:0]   next_idx;
  logic [SUM_W-1:0]   next_sum;
  logic               handshake;
  logic               start_accept;
  logic               sample_take;
  logic               frame_done;
  logic               dropped;
  logic               take_new;

  assign handshake    = Peak_Valid && Peak_Ready;
  assign start_accept = Start && ((state == IDLE) || ((state == HOLD) && handshake));
  assign sample_take  = (state == ACCUM) && Mag_Valid;
  assign frame_done   = sample_take && frame_last;
  assign dropped      = Mag_Valid && (state != ACCUM);
  assign Busy         = (state != IDLE);

  mag_frame_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (start_accept),
    .Inc     (sample_take),
    .Count   (count),
    .Last    (frame_last)
  );

  // First sample of a frame always loads; later ones need a strictly larger value so ties keep the earliest index.
  assign take_new  = (count == '0) || (Magnitude > run_peak);
  assign next_peak = take_new ? Magnitude : run_peak;
  assign next_idx  = take_new ? count : run_idx;
  assign next_sum  = run_sum + {{IDX_W{1'b0}}, Magnitude};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = ACCUM;
      ACCUM:   if (frame_done) state_next = HOLD;
      HOLD:    if (handshake) state_next = Start ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Running accumulators, result registers and the sticky overrun flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_peak   <= '0;
      run_idx    <= '0;
      run_sum    <= '0;
      Peak_Mag   <= '0;
      Peak_Idx   <= '0;
      Mag_Sum    <= '0;
      Peak_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      if (start_accept) begin
        run_peak <= '0;
        run_idx  <= '0;
        run_sum  <= '0;
      end else if (sample_take) begin
        run_peak <= next_peak;
        run_idx  <= next_idx;
        run_sum  <= next_sum;
      end

      if (frame_done) begin
        Peak_Mag   <= next_peak;
        Peak_Idx   <= next_idx;
        Mag_Sum    <= next_sum;
        Peak_Valid <= 1'b1;
      end else if (handshake) begin
        Peak_Valid <= 1'b0;
      end

      // A sample dropped in the same cycle as an accepted Start still counts as lost.
      if (dropped) begin
        Overrun <= 1'b1;
      end else if (start_accept) begin
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Directed self-checking bench: an 8-sample instance for most scenarios and a 64-sample one for full scale.
module tb_magnitude_peak_detector;

  logic        Clk = 1'b0;
  logic        Reset_n;

  logic        Start, Mag_Valid, Peak_Ready;
  logic [12:0] Magnitude;
  logic        Peak_Valid, Busy, Overrun;
  logic [12:0] Peak_Mag;
  logic [2:0]  Peak_Idx;
  logic [15:0] Mag_Sum;

  logic        Start64, Mag_Valid64, Peak_Ready64;
  logic [12:0] Magnitude64;
  logic        Peak_Valid64, Busy64, Overrun64;
  logic [12:0] Peak_Mag64;
  logic [5:0]  Peak_Idx64;
  logic [18:0] Mag_Sum64;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  magnitude_peak_detector #(.FRAME_LEN(8), .MAG_W(13)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mag_Valid(Mag_Valid),
    .Magnitude(Magnitude), .Peak_Valid(Peak_Valid), .Peak_Ready(Peak_Ready),
    .Peak_Mag(Peak_Mag), .Peak_Idx(Peak_Idx), .Mag_Sum(Mag_Sum),
    .Busy(Busy), .Overrun(Overrun)
  );

  magnitude_peak_detector #(.FRAME_LEN(64), .MAG_W(13)) dut64 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start64), .Mag_Valid(Mag_Valid64),
    .Magnitude(Magnitude64), .Peak_Valid(Peak_Valid64), .Peak_Ready(Peak_Ready64),
    .Peak_Mag(Peak_Mag64), .Peak_Idx(Peak_Idx64), .Mag_Sum(Mag_Sum64),
    .Busy(Busy64), .Overrun(Overrun64)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [12:0] v);
    Mag_Valid = 1'b1;
    Magnitude = v;
    tick();
    Mag_Valid = 1'b0;
    Magnitude = 13'd0;
  endtask

  task automatic test_reset_initial();
    tick();
    tick();
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL init_valid actual=%0b expected=0", Peak_Valid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL init_busy actual=%0b expected=0", Busy); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL init_overrun actual=%0b expected=0", Overrun); end
    checks++; if (Mag_Sum !== 16'd0) begin failures++; $display("FAIL init_sum actual=%0d expected=0", Mag_Sum); end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    Peak_Ready = 1'b1;
    pulse_start();
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL ramp_busy actual=%0b expected=1", Busy); end
    for (int i = 1; i <= 7; i++) send(13'(i));
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL ramp_early_valid actual=%0b expected=0", Peak_Valid); end
    send(13'd8);
    checks++; if (Peak_Valid !== 1'b1) begin failures++; $display("FAIL ramp_valid actual=%0b expected=1", Peak_Valid); end
    checks++; if (Peak_Mag !== 13'd8) begin failures++; $display("FAIL ramp_mag actual=%0d expected=8", Peak_Mag); end
    checks++; if (Peak_Idx !== 3'd7) begin failures++; $display("FAIL ramp_idx actual=%0d expected=7", Peak_Idx); end
    checks++; if (Mag_Sum !== 16'd36) begin failures++; $display("FAIL ramp_sum actual=%0d expected=36", Mag_Sum); end
    tick();
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL ramp_valid_clear actual=%0b expected=0", Peak_Valid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL ramp_busy_clear actual=%0b expected=0", Busy); end
    checks++; if (Peak_Mag !== 13'd8) begin failures++; $display("FAIL ramp_mag_hold actual=%0d expected=8", Peak_Mag); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL ramp_overrun actual=%0b expected=0", Overrun); end
  endtask

  task automatic test_tie_gaps();
    logic [12:0] vals [8] = '{13'd5, 13'd9, 13'd2, 13'd9, 13'd0, 13'd0, 13'd0, 13'd1};
    Peak_Ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      int ngap = $urandom_range(0, 3);
      for (int g = 0; g < ngap; g++) begin
        Mag_Valid = 1'b0;
        Magnitude = 13'd4000;
        tick();
      end
      send(vals[i]);
    end
    checks++; if (Peak_Valid !== 1'b1) begin failures++; $display("FAIL tie_valid actual=%0b expected=1", Peak_Valid); end
    checks++; if (Peak_Mag !== 13'd9) begin failures++; $display("FAIL tie_mag actual=%0d expected=9", Peak_Mag); end
    checks++; if (Peak_Idx !== 3'd1) begin failures++; $display("FAIL tie_idx actual=%0d expected=1", Peak_Idx); end
    checks++; if (Mag_Sum !== 16'd26) begin failures++; $display("FAIL tie_sum actual=%0d expected=26", Mag_Sum); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [12:0] vals [8] = '{13'd3, 13'd7, 13'd7, 13'd1, 13'd6, 13'd2, 13'd0, 13'd5};
    Peak_Ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) send(vals[i]);
    for (int c = 0; c < 5; c++) begin
      Mag_Valid = 1'b1;
      Magnitude = 13'd4095;
      tick();
      checks++; if (Peak_Valid !== 1'b1 || Peak_Mag !== 13'd7 || Peak_Idx !== 3'd1 || Mag_Sum !== 16'd31)
        begin failures++; $display("FAIL bp_hold cycle=%0d actual=%0b/%0d/%0d/%0d expected=1/7/1/31", c, Peak_Valid, Peak_Mag, Peak_Idx, Mag_Sum); end
      checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun cycle=%0d actual=%0b expected=1", c, Overrun); end
    end
    Mag_Valid = 1'b0;
    Peak_Ready = 1'b1;
    tick();
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid actual=%0b expected=0", Peak_Valid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL bp_release_busy actual=%0b expected=0", Busy); end
    checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_sticky actual=%0b expected=1", Overrun); end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    send(13'd50);
    send(13'd60);
    send(13'd70);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy actual=%0b expected=0", Busy); end
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%0b expected=0", Peak_Valid); end
    checks++; if (Peak_Mag !== 13'd0 || Peak_Idx !== 3'd0 || Mag_Sum !== 16'd0)
      begin failures++; $display("FAIL rst_result actual=%0d/%0d/%0d expected=0/0/0", Peak_Mag, Peak_Idx, Mag_Sum); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun actual=%0b expected=0", Overrun); end
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    send(13'd100);
    checks++; if (Overrun !== 1'b1) begin failures++; $display("FAIL idle_drop_overrun actual=%0b expected=1", Overrun); end
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL idle_drop_valid actual=%0b expected=0", Peak_Valid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL idle_drop_busy actual=%0b expected=0", Busy); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] vals [8] = '{13'd10, 13'd20, 13'd30, 13'd40, 13'd50, 13'd60, 13'd70, 13'd1};
    pulse_start();
    for (int i = 0; i < 4; i++) send(13'd4095);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    Peak_Ready = 1'b0;
    pulse_start();
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun_cleared actual=%0b expected=0", Overrun); end
    for (int i = 0; i < 8; i++) send(13'd2);
    checks++; if (Peak_Valid !== 1'b1 || Peak_Mag !== 13'd2 || Peak_Idx !== 3'd0 || Mag_Sum !== 16'd16)
      begin failures++; $display("FAIL clean_frame actual=%0b/%0d/%0d/%0d expected=1/2/0/16", Peak_Valid, Peak_Mag, Peak_Idx, Mag_Sum); end
    Peak_Ready = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_busy actual=%0b expected=1", Busy); end
    checks++; if (Peak_Valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_clear actual=%0b expected=0", Peak_Valid); end
    checks++; if (Peak_Mag !== 13'd2) begin failures++; $display("FAIL b2b_mag_kept actual=%0d expected=2", Peak_Mag); end
    for (int i = 0; i < 8; i++) send(vals[i]);
    checks++; if (Peak_Valid !== 1'b1 || Peak_Mag !== 13'd70 || Peak_Idx !== 3'd6 || Mag_Sum !== 16'd281)
      begin failures++; $display("FAIL b2b_frame actual=%0b/%0d/%0d/%0d expected=1/70/6/281", Peak_Valid, Peak_Mag, Peak_Idx, Mag_Sum); end
    checks++; if (Overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun actual=%0b expected=0", Overrun); end
    tick();
    checks++; if (Busy !== 1'b0 || Peak_Valid !== 1'b0) begin failures++; $display("FAIL b2b_idle actual=%0b/%0b expected=0/0", Busy, Peak_Valid); end
  endtask

  task automatic test_full_scale();
    Peak_Ready64 = 1'b0;
    Start64 = 1'b1;
    tick();
    Start64 = 1'b0;
    Mag_Valid64 = 1'b1;
    Magnitude64 = 13'd4095;
    for (int i = 0; i < 63; i++) tick();
    checks++; if (Peak_Valid64 !== 1'b0) begin failures++; $display("FAIL fs_early_valid actual=%0b expected=0", Peak_Valid64); end
    tick();
    Mag_Valid64 = 1'b0;
    checks++; if (Peak_Valid64 !== 1'b1) begin failures++; $display("FAIL fs_valid actual=%0b expected=1", Peak_Valid64); end
    checks++; if (Peak_Mag64 !== 13'd4095) begin failures++; $display("FAIL fs_mag actual=%0d expected=4095", Peak_Mag64); end
    checks++; if (Peak_Idx64 !== 6'd0) begin failures++; $display("FAIL fs_idx actual=%0d expected=0", Peak_Idx64); end
    checks++; if (Mag_Sum64 !== 19'd262080) begin failures++; $display("FAIL fs_sum actual=%0d expected=262080", Mag_Sum64); end
    Peak_Ready64 = 1'b1;
    tick();
    checks++; if (Peak_Valid64 !== 1'b0 || Busy64 !== 1'b0) begin failures++; $display("FAIL fs_release actual=%0b/%0b expected=0/0", Peak_Valid64, Busy64); end
    checks++; if (Overrun64 !== 1'b0) begin failures++; $display("FAIL fs_overrun actual=%0b expected=0", Overrun64); end
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 1'b0; Mag_Valid = 1'b0; Magnitude = 13'd0; Peak_Ready = 1'b0;
    Start64 = 1'b0; Mag_Valid64 = 1'b0; Magnitude64 = 13'd0; Peak_Ready64 = 1'b0;
    test_reset_initial();
    test_ramp();
    test_tie_gaps();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_full_scale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
